// File: rtl/apb_master_pkg12.sv
// Shared types and sizing for the two-cycle APB initiator.
// A command record is {write, addr[7:0], wdata[31:0]}, 41 bits in total.
package apb_master_pkg12;

    localparam int NUM_SLV    = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int CMD_W      = 1 + 8 + 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo12.sv
// Synchronous command FIFO with a power-of-two depth.
// Push and pop may happen on the same edge, including when the FIFO is full.
module cmd_fifo12 #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 41,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] rdata_nxt,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // rdata_nxt lets the owner start the following transfer on the pop edge.
    assign rdata     = mem_q[rd_ptr_q];
    assign rdata_nxt = mem_q[rd_ptr_q + 1'b1];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign count     = cnt_q;

endmodule

// File: rtl/apb_master12.sv
// Two-cycle APB initiator: buffered commands drive SETUP/ACCESS on one of
// four one-hot selects; read data returns on a one-cycle response pulse.
module apb_master12 #(
    parameter int NUM_SLV    = apb_master_pkg12::NUM_SLV,
    parameter int FIFO_DEPTH = apb_master_pkg12::FIFO_DEPTH
) (
    input  logic                   pclk12,
    input  logic                   n_p_reset12,
    input  logic                   cmd_valid12,
    output logic                   cmd_ready12,
    input  logic                   cmd_write12,
    input  logic [7:0]             cmd_addr12,
    input  logic [31:0]            cmd_wdata12,
    output logic                   rsp_valid12,
    output logic                   rsp_write12,
    output logic [31:0]            rsp_rdata12,
    output logic [NUM_SLV-1:0]     psel12,
    output logic                   penable12,
    output logic                   pwrite12,
    output logic [5:0]             paddr12,
    output logic [31:0]            pwdata12,
    input  logic [NUM_SLV*32-1:0]  prdata12
);
    import apb_master_pkg12::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e               state_q, state_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [5:0]           paddr_q, paddr_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [1:0]           slv_q, slv_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 cmd_ready_q, cmd_ready_d;

    cmd_t                 cmd_in, head, head_nxt, nxt;
    logic                 push, pop, load;
    logic                 fifo_empty, fifo_full;
    logic [CW-1:0]        fifo_cnt, cnt_nxt;

    assign cmd_in = '{write: cmd_write12, addr: cmd_addr12, wdata: cmd_wdata12};

    cmd_fifo12 #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk       (pclk12),
        .rst_n     (n_p_reset12),
        .push      (push),
        .wdata     (cmd_in),
        .pop       (pop),
        .rdata     (head),
        .rdata_nxt (head_nxt),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_cnt)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        slv_d       = slv_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        load        = 1'b0;

        pop  = (state_q == ACCESS);
        push = cmd_valid12 && cmd_ready_q && (!fifo_full || pop);
        case ({push, pop})
            2'b10:   cnt_nxt = fifo_cnt + 1'b1;
            2'b01:   cnt_nxt = fifo_cnt - 1'b1;
            default: cnt_nxt = fifo_cnt;
        endcase
        cmd_ready_d = (cnt_nxt < CW'(FIFO_DEPTH));

        // On the pop edge the follow-on command is either already buffered
        // behind the head or is the one being pushed on this very edge.
        if (state_q != ACCESS)          nxt = head;
        else if (fifo_cnt >= CW'(2))    nxt = head_nxt;
        else                            nxt = cmd_in;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_write_d = pwrite_q;
                if (!pwrite_q) rsp_rdata_d = prdata12[{slv_q, 5'd0} +: 32];
                if (cnt_nxt != '0) begin
                    load = 1'b1;
                end else begin
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d                 = SETUP;
            psel_d                  = '0;
            psel_d[nxt.addr[7:6]]   = 1'b1;
            penable_d               = 1'b0;
            paddr_d                 = nxt.addr[5:0];
            pwrite_d                = nxt.write;
            pwdata_d                = nxt.wdata;
            slv_d                   = nxt.addr[7:6];
        end
    end

    always_ff @(posedge pclk12 or negedge n_p_reset12) begin
        if (!n_p_reset12) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            slv_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            slv_q       <= slv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready12 = cmd_ready_q;
    assign rsp_valid12 = rsp_valid_q;
    assign rsp_write12 = rsp_write_q;
    assign rsp_rdata12 = rsp_rdata_q;
    assign psel12      = psel_q;
    assign penable12   = penable_q;
    assign pwrite12    = pwrite_q;
    assign paddr12     = paddr_q;
    assign pwdata12    = pwdata_q;

endmodule

// File: tb/tb_apb_master12.sv
// Directed bench for apb_master12: responses are scoreboarded in command
// order and APB phase timing is checked at negedges.
module tb_apb_master12;

    logic         pclk12 = 1'b0;
    logic         n_p_reset12;
    logic         cmd_valid12;
    logic         cmd_ready12;
    logic         cmd_write12;
    logic [7:0]   cmd_addr12;
    logic [31:0]  cmd_wdata12;
    logic         rsp_valid12;
    logic         rsp_write12;
    logic [31:0]  rsp_rdata12;
    logic [3:0]   psel12;
    logic         penable12;
    logic         pwrite12;
    logic [5:0]   paddr12;
    logic [31:0]  pwdata12;
    logic [127:0] prdata12;

    logic [31:0]  slv_data [4];

    apb_master12 dut (
        .pclk12      (pclk12),
        .n_p_reset12 (n_p_reset12),
        .cmd_valid12 (cmd_valid12),
        .cmd_ready12 (cmd_ready12),
        .cmd_write12 (cmd_write12),
        .cmd_addr12  (cmd_addr12),
        .cmd_wdata12 (cmd_wdata12),
        .rsp_valid12 (rsp_valid12),
        .rsp_write12 (rsp_write12),
        .rsp_rdata12 (rsp_rdata12),
        .psel12      (psel12),
        .penable12   (penable12),
        .pwrite12    (pwrite12),
        .paddr12     (paddr12),
        .pwdata12    (pwdata12),
        .prdata12    (prdata12)
    );

    always #5 pclk12 = ~pclk12;

    assign prdata12 = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

    typedef struct {
        logic        w;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          rsp_cyc[$];
    int          cyc;
    int          n_assert;
    int          n_fail;
    logic [31:0] model_rd;
    logic        cw [8];
    logic [7:0]  ca [8];
    logic [31:0] cd [8];
    int          ready_lows;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge pclk12) cyc <= cyc + 1;

    // Response monitor: every pulse must match the oldest outstanding command.
    always @(negedge pclk12) begin
        check("psel onehot0", 64'($onehot0(psel12)), 64'd1);
        if (rsp_valid12 === 1'b1) begin
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_write", 64'(rsp_write12), 64'(e.w));
                check("rsp_rdata", 64'(rsp_rdata12), 64'(e.d));
            end
        end
    end

    task automatic push_exp(input logic w, input logic [7:0] a);
        exp_t e;
        if (!w) model_rd = slv_data[a[7:6]];
        e.w = w;
        e.d = model_rd;
        exp_q.push_back(e);
    endtask

    // Present cw/ca/cd[0..n-1] with valid held; returns at the negedge after the last accept.
    task automatic run_cmds(input int n);
        int   k = 0;
        int   budget = 0;
        logic acc;
        ready_lows = 0;
        while (k < n && budget < 200) begin
            cmd_valid12 = 1'b1;
            cmd_write12 = cw[k];
            cmd_addr12  = ca[k];
            cmd_wdata12 = cd[k];
            acc = cmd_ready12;
            if (!acc) ready_lows++;
            @(negedge pclk12);
            budget++;
            if (acc) begin
                push_exp(cw[k], ca[k]);
                k++;
            end
        end
        cmd_valid12 = 1'b0;
        check("cmds accepted", 64'(k), 64'(n));
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_q.size() != 0 || psel12 != 4'b0) && budget < 100) begin
            @(negedge pclk12);
            budget++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        cyc         = 0;
        n_assert    = 0;
        n_fail      = 0;
        model_rd    = '0;
        n_p_reset12 = 1'b0;
        cmd_valid12 = 1'b0;
        cmd_write12 = 1'b0;
        cmd_addr12  = '0;
        cmd_wdata12 = '0;
        for (int i = 0; i < 4; i++) slv_data[i] = 32'h0;

        // Reset state and ready rising one edge after release.
        @(negedge pclk12);
        @(negedge pclk12);
        check("rst outputs", {cmd_ready12, rsp_valid12, rsp_write12, psel12, penable12, pwrite12},
              64'd0);
        check("rst data", {rsp_rdata12, pwdata12}, 64'd0);
        check("rst paddr", 64'(paddr12), 64'd0);
        n_p_reset12 = 1'b1;
        #1 check("ready before edge", 64'(cmd_ready12), 64'd0);
        @(negedge pclk12);
        check("ready after release", 64'(cmd_ready12), 64'd1);

        // Single read from slave 2.
        slv_data[2] = 32'hCAFE_0001;
        cw[0] = 1'b0; ca[0] = 8'h85; cd[0] = 32'h0;
        run_cmds(1);
        check("rd e0 psel", {psel12, penable12}, 64'd0);
        @(negedge pclk12);
        check("rd setup psel", 64'(psel12), 64'b0100);
        check("rd setup pen", 64'(penable12), 64'd0);
        check("rd setup paddr", 64'(paddr12), 64'h05);
        check("rd setup pwrite", 64'(pwrite12), 64'd0);
        @(negedge pclk12);
        check("rd access", {psel12, penable12}, 64'b01001);
        @(negedge pclk12);
        check("rd rsp pulse", {rsp_valid12, rsp_write12}, 64'b10);
        check("rd idle", {psel12, penable12}, 64'd0);
        check("rd idle paddr hold", 64'(paddr12), 64'h05);
        @(negedge pclk12);
        check("rd rsp one cycle", 64'(rsp_valid12), 64'd0);

        // Single write to slave 0.
        cw[0] = 1'b1; ca[0] = 8'h04; cd[0] = 32'h0000_00FF;
        run_cmds(1);
        @(negedge pclk12);
        check("wr setup", {psel12, penable12, pwrite12}, 64'b000101);
        check("wr setup pwdata", 64'(pwdata12), 64'hFF);
        @(negedge pclk12);
        check("wr access", {psel12, penable12, pwrite12}, 64'b000111);
        check("wr access pwdata", 64'(pwdata12), 64'hFF);
        drain();
        check("wr rdata kept", 64'(rsp_rdata12), 64'hCAFE_0001);
        check("wr idle pwdata hold", 64'(pwdata12), 64'hFF);

        // Five mixed commands with valid held: FIFO fills, no IDLE gap.
        slv_data[1] = 32'h1111_2222; slv_data[3] = 32'h3333_4444;
        cw[0] = 0; ca[0] = 8'h41; cd[0] = 32'h0;
        cw[1] = 1; ca[1] = 8'hC2; cd[1] = 32'hA5A5_0001;
        cw[2] = 0; ca[2] = 8'hC3; cd[2] = 32'h0;
        cw[3] = 1; ca[3] = 8'h0A; cd[3] = 32'hA5A5_0002;
        cw[4] = 0; ca[4] = 8'h8B; cd[4] = 32'h0;
        rsp_cyc.delete();
        run_cmds(5);
        check("ready dropped when full", 64'(ready_lows > 0), 64'd1);
        drain();
        check("burst rsp count", 64'(rsp_cyc.size()), 64'd5);
        for (int i = 1; i < rsp_cyc.size(); i++)
            check("burst rsp spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd2);

        // Push on the same edge as the pop: next SETUP starts straight away.
        cw[0] = 0; ca[0] = 8'h01; cd[0] = 32'h0;
        run_cmds(1);
        @(negedge pclk12);
        @(negedge pclk12);
        check("pp access", 64'(penable12), 64'd1);
        cw[0] = 1; ca[0] = 8'hC7; cd[0] = 32'hDEAD_BEEF;
        run_cmds(1);
        check("pp next setup", {psel12, penable12, pwrite12}, 64'b100001);
        check("pp next paddr", 64'(paddr12), 64'h07);
        check("pp ready", 64'(cmd_ready12), 64'd1);
        drain();

        // Reset during ACCESS with a second command buffered.
        cw[0] = 0; ca[0] = 8'h40; cd[0] = 32'h0;
        cw[1] = 1; ca[1] = 8'hC3; cd[1] = 32'h1234_5678;
        run_cmds(2);
        @(negedge pclk12);
        check("pre-reset access", {psel12, penable12}, 64'b00101);
        #2 n_p_reset12 = 1'b0;
        exp_q.delete();
        model_rd = '0;
        #1 check("async rst", {psel12, penable12, cmd_ready12, rsp_valid12}, 64'd0);
        check("async rst paddr", 64'(paddr12), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk12);
            check("no rsp in reset", 64'(rsp_valid12), 64'd0);
        end
        n_p_reset12 = 1'b1;
        @(negedge pclk12);
        check("post-reset ready", 64'(cmd_ready12), 64'd1);
        check("post-reset idle", {psel12, rsp_valid12}, 64'd0);
        @(negedge pclk12);
        check("dropped cmd stays dropped", {psel12, rsp_valid12}, 64'd0);
        slv_data[1] = 32'h5555_AAAA;
        cw[0] = 0; ca[0] = 8'h50; cd[0] = 32'h0;
        run_cmds(1);
        drain();
        check("post-reset rdata", 64'(rsp_rdata12), 64'h5555_AAAA);

        // Reads from every slave with distinct data.
        for (int i = 0; i < 4; i++) begin
            slv_data[i] = 32'hB000_0000 + 32'(i * 32'h0101_0101);
            cw[i] = 1'b0;
            ca[i] = {2'(i), 6'(i + 8)};
            cd[i] = 32'h0;
        end
        run_cmds(4);
        drain();
        check("all-slave last rdata", 64'(rsp_rdata12), 64'hB303_0303);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
